// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the ROM download router.
// Optional checksum block is enabled with macro ROM_DL_CHECKSUM_EN.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam int HOLD_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/rom_dl_packer.sv
// Assembles download bytes into ROM words, emits a registered one-cycle
// region write strobe on the top lane, and flags words left incomplete at LOAD exit.
module rom_dl_packer
  import rom_dl_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_AW   = 14,
  parameter int DATA_W      = 8,
  localparam int LB         = (DATA_W == 16) ? 1 : 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept,
  input  logic                    load_exit,
  input  logic [2:0]              region,
  input  logic [REGION_AW-1:0]    byte_addr,
  input  logic [7:0]              data,
  output logic [NUM_REGIONS-1:0]  rom_wr,
  output logic [REGION_AW-LB-1:0] rom_addr,
  output logic [DATA_W-1:0]       rom_data,
  output logic                    partial
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0]      word_q, word_d, word_emit;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [NUM_REGIONS-1:0] wr_d;
  logic                   emit;
  int                     lane;

  always_comb begin
    lane      = (LB == 1) ? int'(byte_addr[0]) : 0;
    word_emit = word_q;
    word_emit[lane*8 +: 8] = data;
    emit      = accept && (lane == LANES - 1);
    word_d    = word_q;
    mask_d    = mask_q;
    if (accept) begin
      if (emit) begin
        word_d = '0;
        mask_d = '0;
      end else begin
        word_d       = word_emit;
        mask_d[lane] = 1'b1;
      end
    end
    // Any lane still buffered after this cycle's byte is lost when LOAD ends.
    partial = load_exit && (mask_d != '0);
    if (load_exit) begin
      word_d = '0;
      mask_d = '0;
    end
    wr_d = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      wr_d[r] = emit && (region == 3'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      mask_q   <= '0;
      rom_wr   <= '0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      rom_wr <= wr_d;
      if (emit) begin
        rom_addr <= byte_addr[REGION_AW-1:LB];
        rom_data <= word_emit;
      end
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// Routes a byte-serial ROM download into per-region word writes and holds the
// core in reset until the load completes. Optional checksum: ROM_DL_CHECKSUM_EN.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_AW   = 14,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  localparam int LB         = (DATA_W == 16) ? 1 : 0,
  localparam int SEL_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    dn_download,
  input  logic                    dn_wr,
  input  logic [REGION_AW+2:0]    dn_addr,
  input  logic [7:0]              dn_data,
`ifdef ROM_DL_CHECKSUM_EN
  input  logic [SEL_W-1:0]        chk_sel,
  output logic [15:0]             chk_sum,
`endif
  output logic [NUM_REGIONS-1:0]  rom_wr,
  output logic [REGION_AW-LB-1:0] rom_addr,
  output logic [DATA_W-1:0]       rom_data,
  output logic                    core_reset,
  output logic                    load_done,
  output logic                    err_oob,
  output logic                    err_partial,
  output state_t                  state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       region;
  logic             in_range, load_entry, load_exit, accept, oob_hit, partial;

  assign region     = dn_addr[REGION_AW+2:REGION_AW];
  assign in_range   = (32'(region) < NUM_REGIONS);
  assign load_entry = (state != ST_LOAD) && (state_d == ST_LOAD);
  assign load_exit  = (state == ST_LOAD) && !dn_download;
  assign accept     = (state == ST_LOAD) && dn_wr && in_range;
  assign oob_hit    = (state == ST_LOAD) && dn_wr && !in_range;
  assign core_reset = (state != ST_RUN);
  assign load_done  = (state == ST_RUN);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (dn_download) state_d = ST_LOAD;
      ST_LOAD: if (!dn_download) state_d = ST_HOLD;
      ST_HOLD: begin
        if (dn_download) state_d = ST_LOAD;
        else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN:  if (dn_download) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter is zero on every HOLD entry because it clears whenever HOLD is not continuing.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      err_oob     <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= (state == ST_HOLD && state_d == ST_HOLD) ? hold_cnt + CNT_W'(1) : '0;
      err_oob     <= load_entry ? 1'b0 : (err_oob | oob_hit);
      err_partial <= load_entry ? 1'b0 : (err_partial | partial);
    end
  end

  rom_dl_packer #(
    .NUM_REGIONS(NUM_REGIONS),
    .REGION_AW  (REGION_AW),
    .DATA_W     (DATA_W)
  ) u_packer (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .accept   (accept),
    .load_exit(load_exit),
    .region   (region),
    .byte_addr(dn_addr[REGION_AW-1:0]),
    .data     (dn_data),
    .rom_wr   (rom_wr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .partial  (partial)
  );

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sums [NUM_REGIONS];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGIONS; r++) sums[r] <= '0;
      chk_sum <= '0;
    end else begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (load_entry) sums[r] <= '0;
        else if (accept && region == 3'(r)) sums[r] <= sums[r] + {8'h00, dn_data};
      end
      chk_sum <= (32'(chk_sel) < NUM_REGIONS) ? sums[chk_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: one 8-bit and one 16-bit instance, directed bytes,
// expected-write queues drained by per-instance monitors.
module tb_rom_dl_router;
  import rom_dl_pkg::*;

  localparam int W = 34;  // {rom_wr[3:0], addr[13:0], data[15:0]}

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int           cyc_a_q[$];
  int           cyc_b_q[$];

  // 8-bit instance
  logic        a_dl = 0, a_wr = 0;
  logic [16:0] a_addr = '0;
  logic [7:0]  a_data = '0;
  logic [3:0]  a_rom_wr;
  logic [13:0] a_rom_addr;
  logic [7:0]  a_rom_data;
  logic        a_core_reset, a_load_done, a_err_oob, a_err_partial;
  state_t      a_state;
  // 16-bit instance
  logic        b_dl = 0, b_wr = 0;
  logic [16:0] b_addr = '0;
  logic [7:0]  b_data = '0;
  logic [3:0]  b_rom_wr;
  logic [12:0] b_rom_addr;
  logic [15:0] b_rom_data;
  logic        b_core_reset, b_load_done, b_err_oob, b_err_partial;
  state_t      b_state;
`ifdef ROM_DL_CHECKSUM_EN
  logic [1:0]  a_chk_sel = 2'd2, b_chk_sel = 2'd0;
  logic [15:0] a_chk_sum, b_chk_sum;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_dl_router #(.NUM_REGIONS(4), .REGION_AW(14), .DATA_W(8), .HOLD_CYCLES(16)) u_a (
    .clk_sys(clk), .reset_n(reset_n), .dn_download(a_dl), .dn_wr(a_wr),
    .dn_addr(a_addr), .dn_data(a_data),
`ifdef ROM_DL_CHECKSUM_EN
    .chk_sel(a_chk_sel), .chk_sum(a_chk_sum),
`endif
    .rom_wr(a_rom_wr), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .core_reset(a_core_reset), .load_done(a_load_done),
    .err_oob(a_err_oob), .err_partial(a_err_partial), .state(a_state)
  );

  rom_dl_router #(.NUM_REGIONS(4), .REGION_AW(14), .DATA_W(16), .HOLD_CYCLES(16)) u_b (
    .clk_sys(clk), .reset_n(reset_n), .dn_download(b_dl), .dn_wr(b_wr),
    .dn_addr(b_addr), .dn_data(b_data),
`ifdef ROM_DL_CHECKSUM_EN
    .chk_sel(b_chk_sel), .chk_sum(b_chk_sum),
`endif
    .rom_wr(b_rom_wr), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .core_reset(b_core_reset), .load_done(b_load_done),
    .err_oob(b_err_oob), .err_partial(b_err_partial), .state(b_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drivers: called at a negedge, hold dn_wr for one cycle, return at the next negedge.
  task automatic a_byte(input logic [16:0] addr, input logic [7:0] data, input bit exp_en,
                        input logic [3:0] wr, input logic [13:0] ea, input logic [15:0] ed);
    a_wr = 1'b1; a_addr = addr; a_data = data;
    if (exp_en) begin
      exp_a_q.push_back({wr, ea, ed});
      cyc_a_q.push_back(cyc + 1);
    end
    @(negedge clk);
    a_wr = 1'b0;
  endtask

  task automatic b_byte(input logic [16:0] addr, input logic [7:0] data, input bit exp_en,
                        input logic [3:0] wr, input logic [13:0] ea, input logic [15:0] ed);
    b_wr = 1'b1; b_addr = addr; b_data = data;
    if (exp_en) begin
      exp_b_q.push_back({wr, ea, ed});
      cyc_b_q.push_back(cyc + 1);
    end
    @(negedge clk);
    b_wr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_rom_wr"}, a_rom_wr, 0);
    check({tag, "_a_rom_addr"}, a_rom_addr, 0);
    check({tag, "_a_rom_data"}, a_rom_data, 0);
    check({tag, "_a_core_reset"}, a_core_reset, 1);
    check({tag, "_a_load_done"}, a_load_done, 0);
    check({tag, "_a_errs"}, {a_err_oob, a_err_partial}, 0);
    check({tag, "_a_state"}, a_state, ST_IDLE);
    check({tag, "_b_rom_wr"}, b_rom_wr, 0);
    check({tag, "_b_rom_addr"}, b_rom_addr, 0);
    check({tag, "_b_rom_data"}, b_rom_data, 0);
    check({tag, "_b_core_reset"}, b_core_reset, 1);
    check({tag, "_b_load_done"}, b_load_done, 0);
    check({tag, "_b_errs"}, {b_err_oob, b_err_partial}, 0);
    check({tag, "_b_state"}, b_state, ST_IDLE);
  endtask

  // Monitors: every strobe must match the head of the queue, in the predicted cycle.
  always @(posedge clk) begin
    #1;
    if (a_rom_wr != 0) begin
      if (exp_a_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_write: got wr=%b addr=%0h data=%0h, expected none", a_rom_wr, a_rom_addr, a_rom_data);
      end else begin
        check("a_write", {a_rom_wr, a_rom_addr, 8'h00, a_rom_data}, exp_a_q.pop_front());
        check("a_write_cycle", cyc, cyc_a_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_rom_wr != 0) begin
      if (exp_b_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_write: got wr=%b addr=%0h data=%0h, expected none", b_rom_wr, b_rom_addr, b_rom_data);
      end else begin
        check("b_write", {b_rom_wr, 1'b0, b_rom_addr, b_rom_data}, exp_b_q.pop_front());
        check("b_write_cycle", cyc, cyc_b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;
    @(negedge clk);

    // 8-bit words: one strobe per byte, region from the top address bits
    a_dl = 1'b1;
    @(negedge clk);
    check("a_enter_load", a_state, ST_LOAD);
    a_byte(17'h00000, 8'h11, 1, 4'b0001, 14'd0, 16'h0011);
    a_byte(17'h04001, 8'h22, 1, 4'b0010, 14'd1, 16'h0022);
    a_byte(17'h10000, 8'h55, 0, 4'b0000, 14'd0, 16'h0000);
    check("a_err_oob_set", a_err_oob, 1);

    // Hold length after download ends, then RUN
    a_dl = 1'b0;
    @(negedge clk);
    n = 0;
    while (a_core_reset && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("a_hold_len", n, 16);
    check("a_load_done_run", a_load_done, 1);
    check("a_err_oob_sticky", a_err_oob, 1);
    a_dl = 1'b1;
    @(negedge clk);
    check("a_rerun_core_reset", a_core_reset, 1);
    check("a_rerun_load_done", a_load_done, 0);
    check("a_err_oob_cleared", a_err_oob, 0);

    // Re-entering LOAD from HOLD restarts the full hold period
    a_dl = 1'b0;
    repeat (5) @(negedge clk);
    check("a_mid_hold", a_state, ST_HOLD);
    a_dl = 1'b1;
    @(negedge clk);
    check("a_hold_to_load", a_state, ST_LOAD);
    a_dl = 1'b0;
    @(negedge clk);
    n = 0;
    while (a_core_reset && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("a_hold_restart_len", n, 16);
    a_dl = 1'b1;

    // 16-bit words: little-endian pair, then a lone low byte left at exit
    b_dl = 1'b1;
    @(negedge clk);
    b_byte(17'h00002, 8'hAA, 0, 4'b0000, 14'd0, 16'h0000);
    b_byte(17'h00003, 8'hBB, 1, 4'b0001, 14'd1, 16'hBBAA);
    b_byte(17'h00004, 8'hCC, 0, 4'b0000, 14'd0, 16'h0000);
    check("b_no_partial_yet", b_err_partial, 0);
    b_dl = 1'b0;
    @(negedge clk);
    check("b_err_partial_set", b_err_partial, 1);
    check("b_hold_state", b_state, ST_HOLD);

    // Word completed by a byte coincident with download falling
    b_dl = 1'b1;
    @(negedge clk);
    check("b_err_partial_cleared", b_err_partial, 0);
    b_byte(17'h04006, 8'h12, 0, 4'b0000, 14'd0, 16'h0000);
    b_dl = 1'b0;
    b_byte(17'h04007, 8'h34, 1, 4'b0010, 14'd3, 16'h3412);
    @(negedge clk);
    check("b_coincident_no_partial", b_err_partial, 0);

    // Reset mid-LOAD with a low lane buffered
    b_dl = 1'b1;
    @(negedge clk);
    b_byte(17'h00008, 8'h99, 0, 4'b0000, 14'd0, 16'h0000);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midload");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("b_reload_state", b_state, ST_LOAD);
    b_byte(17'h00003, 8'h77, 1, 4'b0001, 14'd1, 16'h7700);

`ifdef ROM_DL_CHECKSUM_EN
    check("a_chk_reload_state", a_state, ST_LOAD);
    for (int i = 0; i < 257; i++) begin
      a_byte(17'h08000 + 17'(i), 8'hFF, 1, 4'b0100, 14'(i), 16'h00FF);
    end
    repeat (2) @(negedge clk);
    check("a_chk_sum_r2", a_chk_sum, 16'hFFFF);
`endif

    repeat (4) @(negedge clk);
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
